// File: rtl/qtree_mem_ctrl.sv
// -----------------------------------------------------------------------------
// qtree_mem_ctrl
// Configuration/maintenance controller for the quadtree lookup pipeline's
// per-stage node memories. A host command first stops new lookups, then waits
// STAGES cycles so in-flight lookups leave the pipeline. Only then are
// accesses issued on the shared per-stage memory port.
//
// Optional build macro: QTREE_MEM_CTRL_INIT_EN
//   When defined, the controller leaves reset in an INIT sweep. The sweep
//   writes zero to every address of every stage, then enters IDLE.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   lookup_en_i         upstream lookup request
//   lookup_ready_o      lookups permitted
//   lookup_en_o         lookup_en_i gated by lookup_ready_o (to stage 0)
//   cmd_valid_i/_ready_o, cmd_we_i, cmd_stage_i, cmd_addr_i, cmd_wdata_i
//                       host command handshake and payload
//   rsp_valid_o, rsp_err_o, rsp_rdata_o
//                       one-cycle response (read data / bad stage)
//   mem_we_o, mem_re_o  per-stage write/read strobes (registered)
//   mem_addr_o, mem_wdata_o
//                       shared address / write data (registered)
//   mem_rdata_i         concatenated read data, stage s at [s*D_WIDTH +: D_WIDTH]
// -----------------------------------------------------------------------------
module qtree_mem_ctrl #(
  parameter int STAGES    = 5,
  parameter int D_WIDTH   = 16,
  parameter int A_WIDTH   = 10,
  parameter int RD_LAT    = 2,
  parameter int BURST_MAX = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         lookup_en_i,
  output logic                         lookup_ready_o,
  output logic                         lookup_en_o,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic                         cmd_we_i,
  input  logic [$clog2(STAGES)-1:0]    cmd_stage_i,
  input  logic [A_WIDTH-1:0]           cmd_addr_i,
  input  logic [D_WIDTH-1:0]           cmd_wdata_i,
  output logic                         rsp_valid_o,
  output logic                         rsp_err_o,
  output logic [D_WIDTH-1:0]           rsp_rdata_o,
  output logic [STAGES-1:0]            mem_we_o,
  output logic [STAGES-1:0]            mem_re_o,
  output logic [A_WIDTH-1:0]           mem_addr_o,
  output logic [D_WIDTH-1:0]           mem_wdata_o,
  input  logic [STAGES*D_WIDTH-1:0]    mem_rdata_i
);

  localparam int SW = $clog2(STAGES);
  localparam int CW = $clog2(STAGES + 1);
  localparam int OW = $clog2(BURST_MAX + 1);
  localparam int WW = $clog2(RD_LAT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DRAIN   = 3'd1;
  localparam logic [2:0] ACCESS  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] INIT    = 3'd4;

`ifdef QTREE_MEM_CTRL_INIT_EN
  localparam logic [2:0] RST_STATE = INIT;
  localparam logic       RST_READY = 1'b0;
`else
  localparam logic [2:0] RST_STATE = IDLE;
  localparam logic       RST_READY = 1'b1;
`endif

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       drain_q, drain_d;
  logic [OW-1:0]       op_q, op_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [SW-1:0]       rd_stage_q, rd_stage_d;
  logic [A_WIDTH-1:0]  init_addr_q, init_addr_d;
  logic                lookup_ready_q, lookup_ready_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [D_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [STAGES-1:0]   mem_we_q, mem_we_d;
  logic [STAGES-1:0]   mem_re_q, mem_re_d;
  logic [A_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

  logic                accept_s;
  logic                bad_stage_s;
  logic [STAGES-1:0]   stage_onehot_s;

  assign accept_s       = cmd_valid_i & cmd_ready_q;
  assign bad_stage_s    = ({{(32-SW){1'b0}}, cmd_stage_i} >= 32'(STAGES));
  assign stage_onehot_s = {{(STAGES-1){1'b0}}, 1'b1} << cmd_stage_i;

  // Next-state, counters and registered output values.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    op_d        = op_q;
    wait_d      = wait_q;
    rd_stage_d  = rd_stage_q;
    init_addr_d = init_addr_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_we_d    = '0;
    mem_re_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      IDLE: begin
        // Gating on lookup_ready_q guarantees at least one lookup cycle
        // between bursts, and lets a same-cycle lookup pass through.
        if (cmd_valid_i && lookup_ready_q) begin
          state_d = DRAIN;
          drain_d = CW'(STAGES);
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (drain_q <= CW'(1)) begin
          state_d = ACCESS;
          drain_d = '0;
          op_d    = '0;
        end else begin
          drain_d = drain_q - CW'(1);
        end
      end
      ACCESS: begin
        if (accept_s) begin
          op_d = op_q + OW'(1);
          if (bad_stage_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (cmd_we_i) begin
            mem_we_d    = stage_onehot_s;
            mem_addr_d  = cmd_addr_i;
            mem_wdata_d = cmd_wdata_i;
          end else begin
            mem_re_d   = stage_onehot_s;
            mem_addr_d = cmd_addr_i;
            rd_stage_d = cmd_stage_i;
            wait_d     = WW'(RD_LAT);
          end
          if (!bad_stage_s && !cmd_we_i) begin
            state_d = RD_WAIT;
          end else if (op_q == OW'(BURST_MAX - 1)) begin
            state_d = IDLE;
          end else begin
            state_d = ACCESS;
          end
        end else if (!cmd_valid_i) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      RD_WAIT: begin
        // wait_q counts down RD_LAT cycles following the mem_re_o pulse.
        if (wait_q == WW'(0)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rdata_i[rd_stage_q*D_WIDTH +: D_WIDTH];
          state_d     = (op_q == OW'(BURST_MAX)) ? IDLE : ACCESS;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      INIT: begin
        mem_we_d    = {STAGES{1'b1}};
        mem_addr_d  = init_addr_q;
        init_addr_d = init_addr_q + A_WIDTH'(1);
        if (init_addr_q == {A_WIDTH{1'b1}}) begin
          state_d = IDLE;
        end else begin
          state_d = INIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake/permit flags registered from the next state. Lookups stay held
  // off while a strobe from the final accept (or final INIT address) is still
  // being issued.
  always_comb begin
    lookup_ready_d = (state_d == IDLE) && !accept_s && (state_q != INIT);
    cmd_ready_d    = (state_d == ACCESS);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= RST_STATE;
      drain_q        <= '0;
      op_q           <= '0;
      wait_q         <= '0;
      rd_stage_q     <= '0;
      init_addr_q    <= '0;
      lookup_ready_q <= RST_READY;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      mem_we_q       <= '0;
      mem_re_q       <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      drain_q        <= drain_d;
      op_q           <= op_d;
      wait_q         <= wait_d;
      rd_stage_q     <= rd_stage_d;
      init_addr_q    <= init_addr_d;
      lookup_ready_q <= lookup_ready_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_rdata_q    <= rsp_rdata_d;
      mem_we_q       <= mem_we_d;
      mem_re_q       <= mem_re_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign lookup_ready_o = lookup_ready_q;
  assign lookup_en_o    = lookup_en_i & lookup_ready_q;
  assign cmd_ready_o    = cmd_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign mem_we_o       = mem_we_q;
  assign mem_re_o       = mem_re_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;

endmodule

// File: tb/tb_qtree_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qtree_mem_ctrl
// Directed bench for qtree_mem_ctrl (default build). A small node-memory model
// returns rdval on the stage slice RD_LAT cycles after a mem_re_o pulse.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_qtree_mem_ctrl;

  localparam int STAGES  = 5;
  localparam int D_WIDTH = 16;
  localparam int A_WIDTH = 10;

  logic                       clk_i = 1'b0;
  logic                       rst_i = 1'b1;
  logic                       lookup_en_i = 1'b0;
  logic                       lookup_ready_o;
  logic                       lookup_en_o;
  logic                       cmd_valid_i = 1'b0;
  logic                       cmd_ready_o;
  logic                       cmd_we_i = 1'b0;
  logic [2:0]                 cmd_stage_i = 3'd0;
  logic [A_WIDTH-1:0]         cmd_addr_i = 10'd0;
  logic [D_WIDTH-1:0]         cmd_wdata_i = 16'd0;
  logic                       rsp_valid_o;
  logic                       rsp_err_o;
  logic [D_WIDTH-1:0]         rsp_rdata_o;
  logic [STAGES-1:0]          mem_we_o;
  logic [STAGES-1:0]          mem_re_o;
  logic [A_WIDTH-1:0]         mem_addr_o;
  logic [D_WIDTH-1:0]         mem_wdata_o;
  logic [STAGES*D_WIDTH-1:0]  mem_rdata_i;

  logic [STAGES*D_WIDTH-1:0]  p1_q = '0;
  logic [STAGES*D_WIDTH-1:0]  p2_q = '0;
  logic [D_WIDTH-1:0]         rdval = 16'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int drain_en_seen = 0;

  qtree_mem_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lookup_en_i    (lookup_en_i),
    .lookup_ready_o (lookup_ready_o),
    .lookup_en_o    (lookup_en_o),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_we_i       (cmd_we_i),
    .cmd_stage_i    (cmd_stage_i),
    .cmd_addr_i     (cmd_addr_i),
    .cmd_wdata_i    (cmd_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_err_o      (rsp_err_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .mem_we_o       (mem_we_o),
    .mem_re_o       (mem_re_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Node memory model: two register stages give RD_LAT = 2.
  always @(posedge clk_i) begin
    for (int s = 0; s < STAGES; s++) begin
      p1_q[s*D_WIDTH +: D_WIDTH] <= mem_re_o[s] ? rdval : 16'h0000;
    end
    p2_q <= p1_q;
  end
  assign mem_rdata_i = p2_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Presents one command, waits for acceptance and returns in the cycle after
  // the accepting edge (the strobe cycle). drain counts hold-off cycles.
  task automatic do_cmd(input logic we, input logic [2:0] st, input logic [9:0] ad,
                        input logic [15:0] wd, output int drain);
    int n;
    drain = 0;
    n = 0;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_stage_i = st;
    cmd_addr_i  = ad;
    cmd_wdata_i = wd;
    while (!cmd_ready_o && n < 40) begin
      tick();
      if (!lookup_ready_o && !cmd_ready_o) begin
        drain++;
        if (lookup_en_o) drain_en_seen++;
      end
      n++;
    end
    if (!cmd_ready_o) chk("accept_timeout", 32'(0), 32'(1));
    tick();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    int drain;
    int n;
    int nstrobe;
    int idx;
    int win;
    int overlap;
    int rsp_seen;
    logic acc;
    int strobe_cyc [12];

    // ---------------- reset / idle ----------------
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("rst_lookup_ready", 32'(lookup_ready_o), 32'(1));
    chk("rst_cmd_ready",    32'(cmd_ready_o),    32'(0));
    chk("rst_strobes",      32'({mem_we_o, mem_re_o}), 32'(0));
    chk("rst_addr",         32'(mem_addr_o),     32'(0));
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      lookup_en_i = i[0];
      #1;
      chk("idle_lookup_en", 32'(lookup_en_o), 32'(i[0]));
      if (rsp_valid_o || mem_we_o != 5'd0 || mem_re_o != 5'd0) rsp_seen++;
      tick();
    end
    chk("idle_quiet", 32'(rsp_seen), 32'(0));

    // ---------------- write stage 2 during lookups ----------------
    lookup_en_i = 1'b1;
    cmd_valid_i = 1'b1;
    #1;
    chk("wr_same_cycle_lookup", 32'(lookup_en_o), 32'(1));
    drain_en_seen = 0;
    do_cmd(1'b1, 3'd2, 10'h015, 16'hBEEF, drain);
    chk("wr_drain_cycles", 32'(drain), 32'(5));
    chk("wr_drain_gated",  32'(drain_en_seen), 32'(0));
    chk("wr_we",    32'(mem_we_o),    32'(5'b00100));
    chk("wr_addr",  32'(mem_addr_o),  32'(10'h015));
    chk("wr_wdata", 32'(mem_wdata_o), 32'(16'hBEEF));
    chk("wr_hold_lookup", 32'(lookup_ready_o), 32'(0));
    chk("wr_no_rsp", 32'(rsp_valid_o), 32'(0));
    tick();
    chk("wr_we_one_cycle", 32'(mem_we_o), 32'(0));
    chk("wr_release", 32'(lookup_ready_o), 32'(1));
    lookup_en_i = 1'b0;
    tick();

    // ---------------- read stage 4 addr 3 ----------------
    rdval = 16'h1234;
    do_cmd(1'b0, 3'd4, 10'h003, 16'h0000, drain);
    chk("rd_re",    32'(mem_re_o),   32'(5'b10000));
    chk("rd_addr",  32'(mem_addr_o), 32'(10'h003));
    chk("rd_cmd_ready_low", 32'(cmd_ready_o), 32'(0));
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("rd_latency", 32'(n + 1), 32'(4));
    chk("rd_data", 32'(rsp_rdata_o), 32'(16'h1234));
    chk("rd_err",  32'(rsp_err_o),   32'(0));
    tick();
    chk("rd_rsp_pulse", 32'(rsp_valid_o), 32'(0));
    chk("rd_data_hold", 32'(rsp_rdata_o), 32'(16'h1234));
    tick(); tick();

    // ---------------- 12 back-to-back writes ----------------
    nstrobe = 0; idx = 0; win = 0; overlap = 0;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1;
    cmd_stage_i = 3'd0; cmd_addr_i = 10'd0; cmd_wdata_i = 16'hA000;
    for (int k = 0; k < 100 && nstrobe < 12; k++) begin
      acc = cmd_valid_i && cmd_ready_o;
      tick();
      if (mem_we_o != 5'd0) begin
        if (lookup_ready_o) overlap++;
        chk("burst_addr", 32'(mem_addr_o), 32'(nstrobe));
        strobe_cyc[nstrobe] = cyc;
        nstrobe++;
      end else if (nstrobe == 8 && lookup_ready_o) begin
        win++;
      end
      if (acc) begin
        idx++;
        if (idx < 12) begin
          cmd_stage_i = 3'(idx % 5);
          cmd_addr_i  = 10'(idx);
          cmd_wdata_i = 16'hA000 + 16'(idx);
        end else begin
          cmd_valid_i = 1'b0;
        end
      end
    end
    chk("burst_count", 32'(nstrobe), 32'(12));
    if (nstrobe == 12) begin
      chk("burst_first8_consec", 32'(strobe_cyc[7] - strobe_cyc[0]), 32'(7));
      chk("burst_gap",           32'(strobe_cyc[8] - strobe_cyc[7]), 32'(8));
      chk("burst_last4_consec",  32'(strobe_cyc[11] - strobe_cyc[8]), 32'(3));
    end
    chk("burst_lookup_window", 32'(win), 32'(1));
    chk("burst_no_overlap",    32'(overlap), 32'(0));
    tick(); tick();

    // ---------------- bad stage index ----------------
    do_cmd(1'b0, 3'd6, 10'h001, 16'h0000, drain);
    chk("bad_no_strobe", 32'({mem_we_o, mem_re_o}), 32'(0));
    chk("bad_rsp_valid", 32'(rsp_valid_o), 32'(1));
    chk("bad_rsp_err",   32'(rsp_err_o),   32'(1));
    chk("bad_data_hold", 32'(rsp_rdata_o), 32'(16'h1234));
    tick();
    chk("bad_rsp_pulse", 32'(rsp_valid_o), 32'(0));
    tick(); tick();

    // ---------------- reset during RD_WAIT ----------------
    rdval = 16'h5A5A;
    do_cmd(1'b0, 3'd1, 10'h007, 16'h0000, drain);
    chk("rwr_re", 32'(mem_re_o), 32'(5'b00010));
    tick();
    rst_i = 1'b1;
    #1;
    chk("rwr_strobes", 32'({mem_we_o, mem_re_o}), 32'(0));
    chk("rwr_ready",   32'(lookup_ready_o), 32'(1));
    rsp_seen = 0;
    tick(); tick();
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid_o) rsp_seen++;
      tick();
    end
    chk("rwr_no_rsp", 32'(rsp_seen), 32'(0));
    chk("rwr_data_cleared", 32'(rsp_rdata_o), 32'(0));
    chk("rwr_idle_ready", 32'(lookup_ready_o), 32'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qtree_mem_ctrl.md
Name: qtree_mem_ctrl

Overview:
- Configuration/maintenance controller for the per-stage node memories of the quadtree lookup pipeline.
- Accepts host read/write commands, holds off new lookups, and waits for the pipeline to drain.
- Then issues the accesses on a shared per-stage memory port and returns read data.
- Sits between the host control path and the stage array; gates lookup_en into stage 0.

Parameters:
- STAGES, 5, number of pipeline stages / node memories.
- D_WIDTH, 16, node data width.
- A_WIDTH, 10, common memory address bus width (2*STAGES).
- RD_LAT, 2, node memory read latency in cycles (>=1).
- BURST_MAX, 8, max commands served per drain window before lookups are released.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- lookup_en_i  in  1  lookup request from upstream
- lookup_ready_o  out  1  controller permits lookups
- lookup_en_o  out  1  gated lookup enable to stage 0 (lookup_en_i & lookup_ready_o)
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_stage_i  in  $clog2(STAGES)  target stage
- cmd_addr_i  in  A_WIDTH  node address
- cmd_wdata_i  in  D_WIDTH  write data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_err_o  out  1  with rsp_valid_o: bad stage index
- rsp_rdata_o  out  D_WIDTH  read data
- mem_we_o  out  STAGES  per-stage write strobe
- mem_re_o  out  STAGES  per-stage read strobe
- mem_addr_o  out  A_WIDTH  shared address, registered
- mem_wdata_o  out  D_WIDTH  shared write data, registered
- mem_rdata_i  in  STAGES*D_WIDTH  read data, stage s at [s*D_WIDTH +: D_WIDTH]

Behaviour:
- Reset values:
  - all registered outputs 0; FSM in IDLE.
  - lookup_ready_o=1, cmd_ready_o=0.
- FSM states: IDLE, DRAIN, ACCESS, RD_WAIT.
- IDLE:
  - lookup_ready_o=1, cmd_ready_o=0.
  - cmd_valid_i=1 -> DRAIN; drain counter loaded with STAGES; lookup_ready_o=0 from the next cycle.
  - A lookup in the same cycle as cmd_valid_i passes through.
- DRAIN:
  - lookup_ready_o=0; counter decrements each cycle.
  - At 0 -> ACCESS; op counter cleared.
- ACCESS:
  - cmd_ready_o=1.
  - Accepted write: mem_we_o[stage]=1, mem_addr_o/mem_wdata_o valid for exactly one cycle, the cycle after accept. Back-to-back writes are sustained at 1/cycle. No response is generated for a write.
  - Accepted read: mem_re_o[stage]=1 for one cycle after accept; cmd_ready_o=0 from the next cycle; -> RD_WAIT.
  - cmd_stage_i >= STAGES: command consumed, no strobe; rsp_valid_o=1, rsp_err_o=1 the cycle after accept.
  - Each accepted command increments the op counter.
  - Exit to IDLE when cmd_valid_i=0 in ACCESS, or the op counter reaches BURST_MAX. A new command then restarts DRAIN, so lookups are never starved.
- RD_WAIT:
  - Waits RD_LAT cycles after the mem_re_o pulse, then captures the stage slice of mem_rdata_i.
  - Pulses rsp_valid_o with rsp_err_o=0 and rsp_rdata_o = captured data.
  - Returns to ACCESS, or to IDLE if the burst limit was reached.
- Read latency: accept at t -> mem_re_o at t+1 -> rsp_valid_o at t+2+RD_LAT.
- rsp_rdata_o holds its value until the next read response.
- Reset asserted mid-operation: immediate return to IDLE, all strobes cleared, pending read dropped (no rsp).
- Memory strobes are never asserted while lookup_ready_o=1, and never within STAGES cycles of its fall.

Optional Feature:
- QTREE_MEM_CTRL_INIT_EN defined:
  - after reset the FSM starts in INIT with lookup_ready_o=0 and cmd_ready_o=0.
  - Writes 0 to every address 0..2^A_WIDTH-1 of all stages simultaneously (mem_we_o all ones), one address per cycle.
  - Then enters IDLE.
  - Reset during INIT restarts the sweep.
- Undefined: no INIT state; IDLE directly after reset.

Test Plan:
- Reset, idle: lookup_en_i=1 pulses -> lookup_en_o mirrors them; all mem strobes 0; rsp_valid_o never asserts.
- Write stage 2, addr 0x15, data 0xBEEF during lookup traffic:
  - lookup_ready_o drops.
  - Exactly 5 drain cycles.
  - mem_we_o=5'b00100, addr 0x015, wdata 0xBEEF for one cycle.
  - Then lookup_ready_o=1.
- Read stage 4 addr 0x3 with model returning 0x1234 at RD_LAT=2 -> rsp_valid_o exactly 4 cycles after accept, rsp_rdata_o=0x1234, rsp_err_o=0.
- 12 back-to-back writes:
  - 8 strobes in consecutive cycles.
  - Return to IDLE (lookups allowed ≥1 cycle).
  - New drain of 5, then remaining 4 writes.
- cmd_stage_i=6 -> no strobe; rsp_valid_o=1 with rsp_err_o=1 next cycle.
- Assert rst_i during RD_WAIT -> strobes 0, no rsp_valid_o, lookup_ready_o=1 (or INIT sweep under QTREE_MEM_CTRL_INIT_EN, 1024 cycles of mem_we_o=5'b11111, addr 0..1023).
